regfile_sb: RTL and testbench

- Parametrised multi-read-port integer register file with an integrated per-register busy scoreboard, for the pipelined RISC core.
- Synchronous write on posedge clk. Same-cycle write-to-read bypass. Register 0 hardwired to zero.
- Issue stage marks destinations pending; writeback clears them. Decode uses the read-side busy flags for RAW interlock and iss_ready for WAW interlock.
- Replaces the single-generation 2-read/1-write file in the decode/writeback path.

---
 rtl/rf_pkg.sv | 14 +
 rtl/regfile_sb_if.sv | 37 +++
 rtl/rf_scoreboard.sv | 67 ++++++
 rtl/regfile_sb.sv | 64 ++++++
 tb/tb_regfile_sb.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rf_pkg.sv
// Shared definitions for the register file with busy scoreboard.
// - DefDataW / DefNumRegs : default configuration of the integer file
// - REG_ZERO              : index of the hardwired-zero register
// - reg_idx_t             : register index type for the default configuration
package rf_pkg;

  localparam int unsigned DefDataW   = 32;
  localparam int unsigned DefNumRegs = 32;
  localparam int unsigned DefNumRd   = 2;
  localparam int unsigned REG_ZERO   = 0;

  typedef logic [$clog2(DefNumRegs)-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_sb_if.sv
// Bus between the core (decode/issue/writeback) and the register file.
// - rd_addr/rd_data/rd_busy : packed read ports, port k at [k*W +: W]
// - wr_en/wr_addr/wr_data   : writeback
// - iss_en/iss_addr/iss_ready : issue-side destination marking
// - flush                   : clear all busy bits
// - busy_cnt                : number of busy registers
// master = core side, slave = register file.
interface regfile_sb_if #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned NUM_RD   = 2
);
  localparam int unsigned ADDR_W = $clog2(NUM_REGS);

  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     iss_en;
  logic [ADDR_W-1:0]        iss_addr;
  logic                     iss_ready;
  logic                     flush;
  logic [ADDR_W:0]          busy_cnt;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
    input  rd_data, rd_busy, iss_ready, busy_cnt
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
    output rd_data, rd_busy, iss_ready, busy_cnt
  );

endinterface

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard.
// - clk, rst_n      : clock, asynchronous active-low reset
// - iss_en_i/iss_addr_i : issue request marking a destination pending
// - wr_en_i/wr_addr_i   : writeback clearing a pending destination
// - flush_i         : synchronous clear of every busy bit
// - busy_o          : busy bit per register (bit 0 always 0)
// - iss_ready_o     : issue may be accepted this cycle
// - busy_cnt_o      : registered population count of busy_o
module rf_scoreboard import rf_pkg::*; #(
  parameter int unsigned NUM_REGS = DefNumRegs,
  localparam int unsigned ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                iss_en_i,
  input  logic [ADDR_W-1:0]   iss_addr_i,
  input  logic                wr_en_i,
  input  logic [ADDR_W-1:0]   wr_addr_i,
  input  logic                flush_i,
  output logic [NUM_REGS-1:0] busy_o,
  output logic                iss_ready_o,
  output logic [ADDR_W:0]     busy_cnt_o
);

  localparam logic [ADDR_W-1:0] Zero = ADDR_W'(REG_ZERO);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic                set, clr, inc, dec, same_reg;

  always_comb begin
    same_reg    = (wr_addr_i == iss_addr_i);
    // A writeback to the same register frees the slot for a new producer.
    iss_ready_o = !busy_q[iss_addr_i] || (wr_en_i && same_reg) || (iss_addr_i == Zero);
    set         = iss_en_i && iss_ready_o && !flush_i && (iss_addr_i != Zero);
    clr         = wr_en_i && (wr_addr_i != Zero) && busy_q[wr_addr_i];

    busy_d = busy_q;
    if (clr) busy_d[wr_addr_i] = 1'b0;
    if (set) busy_d[iss_addr_i] = 1'b1;   // new producer wins over writeback
    if (flush_i) busy_d = '0;
    busy_d[Zero] = 1'b0;

    // Set on an already-busy bit (re-issue over a writeback) nets to zero change.
    inc = set && !busy_q[iss_addr_i];
    dec = clr && !(set && same_reg);
    if (flush_i) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + (ADDR_W+1)'(inc) - (ADDR_W+1)'(dec);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_o     = busy_q;
  assign busy_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port integer register file with integrated busy scoreboard.
// - clk, rst_n : clock, asynchronous active-low reset
// - bus        : regfile_sb_if slave (read ports, writeback, issue, flush, busy_cnt)
// Reads are combinational with same-cycle writeback bypass; register 0 reads as zero.
module regfile_sb import rf_pkg::*; #(
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned NUM_REGS = DefNumRegs,
  parameter int unsigned NUM_RD   = DefNumRd,
  localparam int unsigned ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic         clk,
  input  logic         rst_n,
  regfile_sb_if.slave  bus
);

  localparam logic [ADDR_W-1:0] Zero = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic                wr_en_g, iss_en_g, wr_fire;

  // Inputs are gated so reset forces outputs to the reset state even with
  // a writeback or issue presented in the same cycle.
  assign wr_en_g  = rst_n && bus.wr_en;
  assign iss_en_g = rst_n && bus.iss_en;
  assign wr_fire  = wr_en_g && (bus.wr_addr != Zero);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
    end else if (wr_fire) begin
      regs_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  rf_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .iss_en_i    (iss_en_g),
    .iss_addr_i  (bus.iss_addr),
    .wr_en_i     (wr_en_g),
    .wr_addr_i   (bus.wr_addr),
    .flush_i     (bus.flush),
    .busy_o      (busy),
    .iss_ready_o (bus.iss_ready),
    .busy_cnt_o  (bus.busy_cnt)
  );

  for (genvar k = 0; k < int'(NUM_RD); k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              byp;

    assign addr = bus.rd_addr[k*ADDR_W +: ADDR_W];
    assign byp  = wr_fire && (bus.wr_addr == addr);

    assign bus.rd_data[k*DATA_W +: DATA_W] = (addr == Zero) ? '0 :
                                             byp            ? bus.wr_data :
                                                              regs_q[addr];
    assign bus.rd_busy[k] = byp ? 1'b0 : busy[addr];
  end

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

  localparam int SelData = 0;
  localparam int SelBusy = 1;
  localparam int SelRdy  = 2;
  localparam int SelCnt  = 3;

  typedef struct packed {
    int          dut;
    int          sel;
    int          port;
    logic [63:0] v;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  regfile_sb_if #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(2)) bus_a ();
  regfile_sb_if #(.DATA_W(64), .NUM_REGS(16), .NUM_RD(4)) bus_b ();

  regfile_sb #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(2)) u_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a.slave)
  );

  regfile_sb #(.DATA_W(64), .NUM_REGS(16), .NUM_RD(4)) u_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b.slave)
  );

  exp_t  sb_q[$];
  string tag_q[$];
  int    total  = 0;
  int    passed = 0;

  function automatic logic [63:0] obs(int dut, int sel, int port);
    logic [63:0] r;
    r = '0;
    if (dut == 0) begin
      case (sel)
        SelData: r = 64'(bus_a.rd_data[port*32 +: 32]);
        SelBusy: r = 64'(bus_a.rd_busy[port]);
        SelRdy:  r = 64'(bus_a.iss_ready);
        default: r = 64'(bus_a.busy_cnt);
      endcase
    end else begin
      case (sel)
        SelData: r = bus_b.rd_data[port*64 +: 64];
        SelBusy: r = 64'(bus_b.rd_busy[port]);
        SelRdy:  r = 64'(bus_b.iss_ready);
        default: r = 64'(bus_b.busy_cnt);
      endcase
    end
    return r;
  endfunction

  task automatic exp(string tag, int dut, int sel, int port, logic [63:0] v);
    exp_t e;
    e.dut = dut; e.sel = sel; e.port = port; e.v = v;
    sb_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic settle();
    exp_t        e;
    string       t;
    logic [63:0] o;
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      t = tag_q.pop_front();
      o = obs(e.dut, e.sel, e.port);
      total++;
      assert (o === e.v) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", t, o, e.v);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic wr_a(logic en, int a, logic [31:0] d);
    bus_a.wr_en = en; bus_a.wr_addr = 5'(a); bus_a.wr_data = d;
  endtask

  task automatic iss_a(logic en, int a);
    bus_a.iss_en = en; bus_a.iss_addr = 5'(a);
  endtask

  task automatic rd_a(int k, int a);
    bus_a.rd_addr[k*5 +: 5] = 5'(a);
  endtask

  task automatic wr_b(logic en, int a, logic [63:0] d);
    bus_b.wr_en = en; bus_b.wr_addr = 4'(a); bus_b.wr_data = d;
  endtask

  task automatic iss_b(logic en, int a);
    bus_b.iss_en = en; bus_b.iss_addr = 4'(a);
  endtask

  task automatic rd_b(int k, int a);
    bus_b.rd_addr[k*4 +: 4] = 4'(a);
  endtask

  initial begin
    rst_n = 1'b0;
    bus_a.rd_addr = '0; bus_a.flush = 1'b0;
    bus_b.rd_addr = '0; bus_b.flush = 1'b0;
    wr_a(0, 0, 0); iss_a(0, 0); wr_b(0, 0, 0); iss_b(0, 0);

    // 1. Reset
    repeat (3) @(posedge clk);
    #2;
    exp("rst_data0", 0, SelData, 0, 0); exp("rst_data1", 0, SelData, 1, 0);
    exp("rst_busy0", 0, SelBusy, 0, 0); exp("rst_busy1", 0, SelBusy, 1, 0);
    exp("rst_cnt", 0, SelCnt, 0, 0);    exp("rst_ready", 0, SelRdy, 0, 1);
    exp("rst_cnt_b", 1, SelCnt, 0, 0);  exp("rst_ready_b", 1, SelRdy, 0, 1);
    settle();
    rst_n = 1'b1;
    exp("post_rst_cnt", 0, SelCnt, 0, 0); exp("post_rst_ready", 0, SelRdy, 0, 1);
    settle();
    wr_a(1, 5, 32'hDEADBEEF);
    cyc();
    wr_a(0, 0, 0); rd_a(0, 5);
    exp("r5_written", 0, SelData, 0, 32'hDEADBEEF);
    settle();
    #1 rst_n = 1'b0;
    exp("r5_async_rst", 0, SelData, 0, 0);
    settle();
    cyc();
    rst_n = 1'b1;
    exp("r5_after_rst", 0, SelData, 0, 0);
    settle();

    // 2. Write / read / bypass
    wr_a(1, 7, 32'h12345678);
    cyc();
    wr_a(1, 9, 32'hA5A5A5A5); rd_a(0, 7); rd_a(1, 9);
    exp("r7_read", 0, SelData, 0, 32'h12345678);
    exp("r9_bypass", 0, SelData, 1, 32'hA5A5A5A5);
    exp("r9_bypass_busy", 0, SelBusy, 1, 0);
    settle();
    cyc();
    wr_a(0, 0, 0);
    exp("r9_stored", 0, SelData, 1, 32'hA5A5A5A5);
    settle();

    // 3. Register zero
    wr_a(1, 0, 32'hFFFFFFFF); iss_a(1, 0); rd_a(0, 0);
    exp("r0_bypass_blocked", 0, SelData, 0, 0);
    exp("r0_busy", 0, SelBusy, 0, 0);
    exp("r0_ready", 0, SelRdy, 0, 1);
    settle();
    cyc();
    wr_a(0, 0, 0); iss_a(0, 0);
    exp("r0_read", 0, SelData, 0, 0);
    exp("r0_busy_after", 0, SelBusy, 0, 0);
    exp("r0_cnt", 0, SelCnt, 0, 0);
    settle();

    // 4. Scoreboard RAW/WAW
    iss_a(1, 3);
    exp("r3_ready", 0, SelRdy, 0, 1);
    settle();
    cyc();
    iss_a(0, 0); rd_a(0, 3);
    exp("r3_busy", 0, SelBusy, 0, 1);
    exp("r3_cnt1", 0, SelCnt, 0, 1);
    settle();
    iss_a(1, 3);
    exp("r3_waw_block", 0, SelRdy, 0, 0);
    settle();
    cyc();
    iss_a(0, 0);
    exp("r3_cnt_hold", 0, SelCnt, 0, 1);
    settle();
    wr_a(1, 3, 32'h55); iss_a(1, 3);
    exp("r3_reiss_ready", 0, SelRdy, 0, 1);
    exp("r3_wb_bypass", 0, SelData, 0, 32'h55);
    exp("r3_wb_bypass_busy", 0, SelBusy, 0, 0);
    settle();
    cyc();
    wr_a(0, 0, 0); iss_a(0, 0);
    exp("r3_reiss_busy", 0, SelBusy, 0, 1);
    exp("r3_reiss_cnt", 0, SelCnt, 0, 1);
    exp("r3_data", 0, SelData, 0, 32'h55);
    settle();
    wr_a(1, 3, 32'h55);
    cyc();
    wr_a(0, 0, 0);
    exp("r3_cleared", 0, SelBusy, 0, 0);
    exp("r3_cnt0", 0, SelCnt, 0, 0);
    settle();

    // Independent events on different registers; writeback to a non-busy one
    iss_a(1, 10); wr_a(1, 11, 32'hCAFE0011);
    cyc();
    iss_a(0, 0); wr_a(0, 0, 0); rd_a(0, 10); rd_a(1, 11);
    exp("r10_busy", 0, SelBusy, 0, 1);
    exp("r11_not_busy", 0, SelBusy, 1, 0);
    exp("r11_data", 0, SelData, 1, 32'hCAFE0011);
    exp("indep_cnt", 0, SelCnt, 0, 1);
    settle();
    wr_a(1, 10, 32'h10); iss_a(1, 12);
    cyc();
    wr_a(0, 0, 0); iss_a(0, 0);
    exp("swap_cnt", 0, SelCnt, 0, 1);
    exp("r10_freed", 0, SelBusy, 0, 0);
    settle();

    // 5. Flush
    iss_a(1, 1); cyc();
    iss_a(1, 2); cyc();
    iss_a(1, 4); cyc();
    iss_a(0, 0);
    exp("pre_flush_cnt", 0, SelCnt, 0, 4);
    settle();
    bus_a.flush = 1'b1; iss_a(1, 6);
    exp("flush_ready", 0, SelRdy, 0, 1);
    settle();
    cyc();
    bus_a.flush = 1'b0; iss_a(0, 0); rd_a(0, 6); rd_a(1, 1);
    exp("flush_cnt", 0, SelCnt, 0, 0);
    exp("flush_r6", 0, SelBusy, 0, 0);
    exp("flush_r1", 0, SelBusy, 1, 0);
    settle();
    rd_a(0, 7); rd_a(1, 3);
    exp("flush_r7_data", 0, SelData, 0, 32'h12345678);
    exp("flush_r3_data", 0, SelData, 1, 32'h55);
    settle();

    // 6. Wide configuration: 4 read ports, 16 regs, 64 bits
    wr_b(1, 7, 64'h0123456789ABCDEF); cyc();
    wr_b(1, 12, 64'hFEDCBA9876543210); cyc();
    wr_b(1, 9, 64'hA5A5A5A5A5A5A5A5);
    rd_b(0, 7); rd_b(1, 9); rd_b(2, 12); rd_b(3, 0);
    exp("b_p0_r7", 1, SelData, 0, 64'h0123456789ABCDEF);
    exp("b_p1_byp", 1, SelData, 1, 64'hA5A5A5A5A5A5A5A5);
    exp("b_p2_r12", 1, SelData, 2, 64'hFEDCBA9876543210);
    exp("b_p3_r0", 1, SelData, 3, 0);
    settle();
    cyc();
    wr_b(0, 0, 0);
    iss_b(1, 3);
    cyc();
    rd_b(3, 3);
    exp("b_r3_busy", 1, SelBusy, 3, 1);
    exp("b_r3_block", 1, SelRdy, 0, 0);
    exp("b_cnt1", 1, SelCnt, 0, 1);
    settle();
    iss_b(1, 3); wr_b(1, 3, 64'h55);
    cyc();
    iss_b(0, 0); wr_b(0, 0, 0);
    exp("b_r3_reiss_busy", 1, SelBusy, 3, 1);
    exp("b_r3_reiss_cnt", 1, SelCnt, 0, 1);
    exp("b_r3_data", 1, SelData, 3, 64'h55);
    settle();
    wr_b(1, 3, 64'h55); cyc(); wr_b(0, 0, 0);
    exp("b_cnt0", 1, SelCnt, 0, 0);
    settle();
    for (int r = 1; r < 16; r++) begin
      iss_b(1, r);
      cyc();
    end
    iss_b(1, 5);
    exp("b_cnt_full", 1, SelCnt, 0, 15);
    exp("b_full_block", 1, SelRdy, 0, 0);
    settle();
    iss_b(1, 0);
    exp("b_r0_ready_full", 1, SelRdy, 0, 1);
    settle();
    cyc();
    iss_b(0, 0);
    exp("b_cnt_sat", 1, SelCnt, 0, 15);
    settle();
    bus_b.flush = 1'b1; cyc(); bus_b.flush = 1'b0;
    exp("b_flush_cnt", 1, SelCnt, 0, 0);
    settle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
